// File: rtl/dispatch_pkg.sv
// Shared constants and types for the operand dispatch stage.
package dispatch_pkg;

  localparam int N_DEF      = 16;
  localparam int OPW_DEF    = 4;
  localparam int NUM_FU_DEF = 2;

  typedef logic [$clog2(NUM_FU_DEF)-1:0] fu_idx_t;

  typedef enum logic [0:0] {
    FU_ALU   = 1'b0,
    FU_SHIFT = 1'b1
  } fu_e;

  // op_codes 0..4 target the ALU, 5..9 the shifter
  localparam logic [OPW_DEF-1:0] OPC_0 = 4'b0000;
  localparam logic [OPW_DEF-1:0] OPC_1 = 4'b0001;
  localparam logic [OPW_DEF-1:0] OPC_2 = 4'b0010;
  localparam logic [OPW_DEF-1:0] OPC_3 = 4'b0011;
  localparam logic [OPW_DEF-1:0] OPC_4 = 4'b0100;
  localparam logic [OPW_DEF-1:0] OPC_5 = 4'b0101;
  localparam logic [OPW_DEF-1:0] OPC_6 = 4'b0110;
  localparam logic [OPW_DEF-1:0] OPC_7 = 4'b0111;
  localparam logic [OPW_DEF-1:0] OPC_8 = 4'b1000;
  localparam logic [OPW_DEF-1:0] OPC_9 = 4'b1001;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear that wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/operand_dispatch.sv
// Registered operand dispatch: decodes the target FU from op_code and holds
// one operand slot presented to that FU through a valid/ready handshake.
module operand_dispatch
  import dispatch_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int OPW        = OPW_DEF,
  parameter int NUM_FU     = NUM_FU_DEF,
  parameter int OPS_PER_FU = 5,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPW-1:0]    op_code,
  input  logic [N-1:0]      rs1_in,
  input  logic [N-1:0]      rs2_in,
  output logic [NUM_FU-1:0] fu_valid,
  input  logic [NUM_FU-1:0] fu_ready,
  output logic [OPW-1:0]    fu_op,
  output logic [N-1:0]      inp1,
  output logic [N-1:0]      inp2,
  output logic              illegal_op,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  dispatch_cnt,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam int SEL_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [OPW-1:0]   fu_op_q, fu_op_d;
  logic [N-1:0]     inp1_q, inp1_d;
  logic [N-1:0]     inp2_q, inp2_d;
  logic             illegal_q, illegal_d;

  logic [OPW-1:0]   idx;
  logic             legal;
  logic             drain;
  logic             accept;

  assign idx      = op_code / OPW'(OPS_PER_FU);
  assign legal    = (32'(idx) < 32'(NUM_FU));
  assign drain    = out_valid_q && fu_ready[sel_q];
  assign in_ready = !out_valid_q || drain;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    sel_d       = sel_q;
    fu_op_d     = fu_op_q;
    inp1_d      = inp1_q;
    inp2_d      = inp2_q;
    illegal_d   = accept && !legal;
    if (accept && legal) begin
      out_valid_d = 1'b1;
      sel_d       = SEL_W'(idx);
      fu_op_d     = op_code;
      inp1_d      = rs1_in;
      inp2_d      = rs2_in;
    end else if (drain) begin
      // Emptied slot reads zero so idle FU buses carry no stale operands
      out_valid_d = 1'b0;
      sel_d       = '0;
      fu_op_d     = '0;
      inp1_d      = '0;
      inp2_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sel_q       <= '0;
      fu_op_q     <= '0;
      inp1_q      <= '0;
      inp2_q      <= '0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      sel_q       <= sel_d;
      fu_op_q     <= fu_op_d;
      inp1_q      <= inp1_d;
      inp2_q      <= inp2_d;
      illegal_q   <= illegal_d;
    end
  end

  always_comb begin
    fu_valid = '0;
    for (int i = 0; i < NUM_FU; i++)
      fu_valid[i] = out_valid_q && (sel_q == SEL_W'(i));
  end

  assign fu_op      = fu_op_q;
  assign inp1       = inp1_q;
  assign inp2       = inp2_q;
  assign illegal_op = illegal_q;

  sat_counter #(.CNT_W(CNT_W)) u_dispatch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drain),
    .clr   (clr_cnt),
    .cnt   (dispatch_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_illegal_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept && !legal),
    .clr   (clr_cnt),
    .cnt   (illegal_cnt)
  );

endmodule

// File: tb/tb_operand_dispatch.sv
// Directed bench for operand_dispatch; a second instance with 2-bit counters
// shares the stimulus to exercise saturation.
module tb_operand_dispatch;
  import dispatch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  op_code;
  logic [15:0] rs1_in, rs2_in;
  logic [1:0]  fu_ready;
  logic        clr_cnt;

  logic        in_ready, illegal_op;
  logic [1:0]  fu_valid;
  logic [3:0]  fu_op;
  logic [15:0] inp1, inp2, dispatch_cnt, illegal_cnt;

  logic        s_in_ready, s_illegal_op;
  logic [1:0]  s_fu_valid;
  logic [3:0]  s_fu_op;
  logic [15:0] s_inp1, s_inp2;
  logic [1:0]  s_dispatch_cnt, s_illegal_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  operand_dispatch dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_code(op_code), .rs1_in(rs1_in), .rs2_in(rs2_in),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_op(fu_op),
    .inp1(inp1), .inp2(inp2), .illegal_op(illegal_op), .clr_cnt(clr_cnt),
    .dispatch_cnt(dispatch_cnt), .illegal_cnt(illegal_cnt)
  );

  operand_dispatch #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .op_code(op_code), .rs1_in(rs1_in), .rs2_in(rs2_in),
    .fu_valid(s_fu_valid), .fu_ready(fu_ready), .fu_op(s_fu_op),
    .inp1(s_inp1), .inp2(s_inp2), .illegal_op(s_illegal_op), .clr_cnt(clr_cnt),
    .dispatch_cnt(s_dispatch_cnt), .illegal_cnt(s_illegal_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    in_valid = v;
    op_code  = op;
    rs1_in   = a;
    rs2_in   = b;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 16'h0, 16'h0);
    fu_ready = 2'b11;
    clr_cnt  = 1'b0;
    tick();
    tick();
    chk("rst_fu_valid", 32'(fu_valid), 32'h0);
    chk("rst_inp1", 32'(inp1), 32'h0);
    chk("rst_illegal", 32'(illegal_op), 32'h0);
    chk("rst_dcnt", 32'(dispatch_cnt), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    rst_n = 1'b1;
    tick();

    // single op to the ALU
    drive(1'b1, OPC_0, 16'h1234, 16'h00FF);
    tick();
    drive(1'b0, 4'h0, 16'h0, 16'h0);
    chk("t1_fu_valid", 32'(fu_valid), 32'h1);
    chk("t1_inp1", 32'(inp1), 32'h1234);
    chk("t1_inp2", 32'(inp2), 32'h00FF);
    chk("t1_fu_op", 32'(fu_op), 32'h0);
    chk("t1_dcnt_pre", 32'(dispatch_cnt), 32'h0);
    tick();
    chk("t1_dcnt", 32'(dispatch_cnt), 32'h1);
    chk("t1_idle_fv", 32'(fu_valid), 32'h0);
    chk("t1_idle_inp1", 32'(inp1), 32'h0);

    // back-to-back 3, 7, 4
    drive(1'b1, OPC_3, 16'h0003, 16'h0030);
    chk("t2_rdy0", 32'(in_ready), 32'h1);
    tick();
    drive(1'b1, OPC_7, 16'h0007, 16'h0070);
    chk("t2_fv_a", 32'(fu_valid), 32'h1);
    chk("t2_rdy_a", 32'(in_ready), 32'h1);
    tick();
    drive(1'b1, OPC_4, 16'h0004, 16'h0040);
    chk("t2_fv_b", 32'(fu_valid), 32'h2);
    chk("t2_op_b", 32'(fu_op), 32'h7);
    chk("t2_rdy_b", 32'(in_ready), 32'h1);
    tick();
    drive(1'b0, 4'h0, 16'h0, 16'h0);
    chk("t2_fv_c", 32'(fu_valid), 32'h1);
    chk("t2_inp2_c", 32'(inp2), 32'h0040);
    tick();
    chk("t2_fv_idle", 32'(fu_valid), 32'h0);
    chk("t2_dcnt", 32'(dispatch_cnt), 32'h4);
    chk("t2_sat_dcnt", 32'(s_dispatch_cnt), 32'h3);

    // back-pressure on FU1; FU0 ready must not drain it
    fu_ready = 2'b01;
    drive(1'b1, OPC_7, 16'hAAAA, 16'h5555);
    tick();
    drive(1'b1, OPC_2, 16'hBBBB, 16'hCCCC);
    for (int i = 0; i < 3; i++) begin
      chk("t3_fv_hold", 32'(fu_valid), 32'h2);
      chk("t3_inp1_hold", 32'(inp1), 32'hAAAA);
      chk("t3_inp2_hold", 32'(inp2), 32'h5555);
      chk("t3_rdy_low", 32'(in_ready), 32'h0);
      tick();
    end
    fu_ready = 2'b11;
    #1;
    chk("t3_rdy_rise", 32'(in_ready), 32'h1);
    tick();
    drive(1'b0, 4'h0, 16'h0, 16'h0);
    chk("t3_fv_second", 32'(fu_valid), 32'h1);
    chk("t3_inp1_second", 32'(inp1), 32'hBBBB);
    chk("t3_op_second", 32'(fu_op), 32'h2);
    tick();
    chk("t3_dcnt", 32'(dispatch_cnt), 32'h6);

    // illegal opcode 0xC
    drive(1'b1, 4'hC, 16'hDEAD, 16'hBEEF);
    chk("t4_rdy", 32'(in_ready), 32'h1);
    tick();
    drive(1'b0, 4'h0, 16'h0, 16'h0);
    chk("t4_pulse", 32'(illegal_op), 32'h1);
    chk("t4_fv", 32'(fu_valid), 32'h0);
    chk("t4_inp1", 32'(inp1), 32'h0);
    chk("t4_icnt", 32'(illegal_cnt), 32'h1);
    tick();
    chk("t4_pulse_end", 32'(illegal_op), 32'h0);
    chk("t4_icnt_hold", 32'(illegal_cnt), 32'h1);
    chk("t4_dcnt_hold", 32'(dispatch_cnt), 32'h6);

    // clear coincident with a drain, then saturation
    drive(1'b1, OPC_1, 16'h1111, 16'h2222);
    tick();
    drive(1'b0, 4'h0, 16'h0, 16'h0);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("t5_clr_dcnt", 32'(dispatch_cnt), 32'h0);
    chk("t5_clr_sat", 32'(s_dispatch_cnt), 32'h0);
    chk("t5_clr_icnt", 32'(illegal_cnt), 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'(2 * i), 16'(i), 16'(i));
      tick();
    end
    drive(1'b0, 4'h0, 16'h0, 16'h0);
    tick();
    chk("t5_dcnt5", 32'(dispatch_cnt), 32'h5);
    chk("t5_sat3", 32'(s_dispatch_cnt), 32'h3);

    // asynchronous reset while a stalled op is pending
    fu_ready = 2'b00;
    drive(1'b1, OPC_0, 16'h7777, 16'h8888);
    tick();
    drive(1'b0, 4'h0, 16'h0, 16'h0);
    chk("t6_pending", 32'(fu_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_fv", 32'(fu_valid), 32'h0);
    chk("t6_async_inp1", 32'(inp1), 32'h0);
    chk("t6_async_dcnt", 32'(dispatch_cnt), 32'h0);
    #1;
    rst_n = 1'b1;
    fu_ready = 2'b11;
    tick();
    chk("t6_no_reissue", 32'(fu_valid), 32'h0);
    tick();
    chk("t6_dcnt_after", 32'(dispatch_cnt), 32'h0);
    chk("t6_inp1_after", 32'(inp1), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/operand_dispatch.md
Name: operand_dispatch

Overview:
- Registered operand dispatch stage between register-file read and the functional units (FUs).
- Accepts one instruction per cycle: op_code plus rs1/rs2 operands. Decodes the target FU from op_code and presents the operands to that FU through a valid/ready handshake.
- Illegal op_codes are dropped and flagged.
- Replaces the earlier combinational opcode-gated rs1 demux: adds rs2 routing, a parametrised FU count, back-pressure and status counters.

Parameters:
- N, 16, operand width in bits.
- OPW, 4, op_code width.
- NUM_FU, 2, number of functional-unit channels (1..8).
- OPS_PER_FU, 5, op_codes per FU. FU index = op_code / OPS_PER_FU; op_codes 0..4 go to FU0, 5..9 go to FU1.
- CNT_W, 16, width of each status counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction presented.
- in_ready  output  1  stage can accept this cycle.
- op_code  input  OPW  instruction opcode.
- rs1_in  input  N  source operand 1.
- rs2_in  input  N  source operand 2.
- fu_valid  output  NUM_FU  one-hot; bit i means FU i has a pending op.
- fu_ready  input  NUM_FU  FU i accepts this cycle.
- fu_op  output  OPW  registered op_code.
- inp1  output  N  registered rs1 operand.
- inp2  output  N  registered rs2 operand.
- illegal_op  output  1  one-cycle pulse, registered, for a dropped illegal op_code.
- clr_cnt  input  1  synchronous clear of both counters.
- dispatch_cnt  output  CNT_W  completed FU handshakes, saturating.
- illegal_cnt  output  CNT_W  dropped illegal ops, saturating.

Behaviour:
- Reset (async assert, sync release in the surrounding design) clears:
  - out_valid, sel, fu_op, inp1, inp2 to 0;
  - illegal_op to 0;
  - both counters to 0.
- Single output slot: out_valid, sel (index of width ceil(log2(NUM_FU)), minimum 1), fu_op, inp1, inp2.
- fu_valid[i] = out_valid && (sel == i). Only one bit is ever set.
- drain = out_valid && fu_ready[sel].
- in_ready = !out_valid || drain. This is combinational; it gives full throughput, one op per cycle with no bubble.
- accept = in_valid && in_ready.
- idx = op_code / OPS_PER_FU. legal = (idx < NUM_FU).
- Accept with legal op, next cycle:
  - out_valid=1, sel=idx, fu_op=op_code, inp1=rs1_in, inp2=rs2_in.
  - Latency from accept to fu_valid is 1 cycle.
- Accept with illegal op:
  - Output slot is not loaded. out_valid = 0 if drain occurred this cycle, otherwise it holds.
  - illegal_op = 1 for exactly the next cycle.
  - illegal_cnt increments.
- No accept and drain: out_valid=0. inp1, inp2 and fu_op are forced to 0 so idle buses read zero.
- No accept and no drain: all slot registers hold. Outputs stay stable while fu_valid is high and fu_ready is low (AXI-style rule).
- fu_ready on a non-selected channel has no effect.
- dispatch_cnt increments on every drain. Both counters saturate at 2^CNT_W-1 and do not wrap.
- clr_cnt has priority over increment: a same-cycle event is lost and the counter reads 0.
- in_valid with in_ready=0: the upstream holds its inputs; nothing is captured.
- Reset mid-transfer: the pending op is discarded and nothing is re-issued.

Decomposition:
- Package dispatch_pkg holds:
  - default N, OPW and NUM_FU constants;
  - fu index typedef;
  - FU enum (FU_ALU=0, FU_SHIFT=1);
  - opcode localparams 4'b0000..4'b1001.
- One sub-module, sat_counter (CNT_W, inc, clr), instantiated twice.
- The decode and the output slot stay in the top module.

Test Plan:
- Reset, then op_code=0, rs1=16'h1234, rs2=16'h00FF, fu_ready=2'b11 → next cycle fu_valid=2'b01, inp1=16'h1234, inp2=16'h00FF; dispatch_cnt=1 one cycle later.
- Back-to-back ops 3, 7, 4 with fu_ready=2'b11 → fu_valid sequence 01, 10, 01 on consecutive cycles; in_ready stays 1 throughout.
- op_code=7 with fu_ready[1]=0 for 3 cycles, a second op presented meanwhile → fu_valid=10 and inp1/inp2 stable; in_ready=0; second op is captured only after fu_ready[1] rises.
- op_code=4'hC (idx 2 ≥ NUM_FU) → no fu_valid; illegal_op is a one-cycle pulse; illegal_cnt=1; inp1 remains 0.
- clr_cnt asserted in the same cycle as a drain → dispatch_cnt=0; with CNT_W=2 and 5 drains → dispatch_cnt=3, no wrap.
- rst_n asserted low while fu_valid=01 and fu_ready=0 → outputs are 0 immediately (asynchronous); after release, no re-issue occurs.
